// File: rtl/lsq_param.sv
// lsq_param: parametrised in-order load/store queue.
// Entries are captured from the decoder and woken up from the CDB channels.
// Ready entries are sent to memory one at a time from the head, and the
// load result is extended and broadcast on completion.
// Optional feature macro: LSQ_MISALIGN_CHK_EN. When it is defined, misaligned
// halfword/word accesses at the head raise out_exc instead of going to memory.
module lsq_param #(
  parameter int DEPTH = 8,
  parameter int ROB_W = 4,
  parameter int CDB_N = 2
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   clear,
  output logic                   full,
  input  logic                   dec_valid,
  input  logic [3:0]             dec_type,
  input  logic [31:0]            dec_vj,
  input  logic [31:0]            dec_vk,
  input  logic                   dec_dj,
  input  logic                   dec_dk,
  input  logic [ROB_W-1:0]       dec_qj,
  input  logic [ROB_W-1:0]       dec_qk,
  input  logic [31:0]            dec_imm,
  input  logic [ROB_W-1:0]       dec_rob_id,
  input  logic [CDB_N-1:0]       cdb_valid,
  input  logic [CDB_N*ROB_W-1:0] cdb_rob_id,
  input  logic [CDB_N*32-1:0]    cdb_value,
  input  logic                   commit_valid,
  input  logic [ROB_W-1:0]       commit_rob_id,
  output logic                   mem_req,
  output logic [31:0]            mem_addr,
  output logic [31:0]            mem_wdata,
  output logic [3:0]             mem_type,
  input  logic                   mem_done,
  input  logic [31:0]            mem_rdata,
  output logic                   out_valid,
  output logic [ROB_W-1:0]       out_rob_id,
  output logic [31:0]            out_value,
  output logic                   out_exc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // Search all CDB channels for a tag; result is {hit, value}. The loop runs
  // from the top channel down so the lowest matching index wins.
  function automatic logic [32:0] cdb_lookup(
    input logic [ROB_W-1:0]       tag,
    input logic [CDB_N-1:0]       vld,
    input logic [CDB_N*ROB_W-1:0] ids,
    input logic [CDB_N*32-1:0]    vals
  );
    logic [32:0] r;
    r = '0;
    for (int c = CDB_N - 1; c >= 0; c--) begin
      if (vld[c] && (ids[c*ROB_W +: ROB_W] == tag)) begin
        r = {1'b1, vals[c*32 +: 32]};
      end
    end
    return r;
  endfunction

  // Extend raw LSB-aligned memory data according to the load type.
  function automatic logic [31:0] load_ext(input logic [3:0] t, input logic [31:0] d);
    logic [31:0] r;
    case (t)
      4'b0000: r = {{24{d[7]}}, d[7:0]};
      4'b0001: r = {{16{d[15]}}, d[15:0]};
      4'b0100: r = {24'd0, d[7:0]};
      4'b0101: r = {16'd0, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  // Entry storage
  logic             busy_q [DEPTH];
  logic [3:0]       typ_q  [DEPTH];
  logic [31:0]      vj_q   [DEPTH];
  logic [31:0]      vk_q   [DEPTH];
  logic             dj_q   [DEPTH];
  logic             dk_q   [DEPTH];
  logic [ROB_W-1:0] qj_q   [DEPTH];
  logic [ROB_W-1:0] qk_q   [DEPTH];
  logic [31:0]      imm_q  [DEPTH];
  logic [ROB_W-1:0] rob_q  [DEPTH];
  logic             cmt_q  [DEPTH];

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic [1:0]       state_q, state_d;

  logic             mem_req_q;
  logic [31:0]      mem_addr_q, mem_wdata_q;
  logic [3:0]       mem_type_q;
  logic             out_valid_q;
  logic [ROB_W-1:0] out_rob_id_q;
  logic [31:0]      out_value_q;

  // Per-entry wakeup lookups and the issue-time bypass lookups
  logic [32:0] wj [DEPTH];
  logic [32:0] wk [DEPTH];
  logic [32:0] ij, ik;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_snoop
      assign wj[gi] = cdb_lookup(qj_q[gi], cdb_valid, cdb_rob_id, cdb_value);
      assign wk[gi] = cdb_lookup(qk_q[gi], cdb_valid, cdb_rob_id, cdb_value);
    end
  endgenerate

  assign ij = cdb_lookup(dec_qj, cdb_valid, cdb_rob_id, cdb_value);
  assign ik = cdb_lookup(dec_qk, cdb_valid, cdb_rob_id, cdb_value);

  // Head view: eligibility uses only registered operand/commit state
  logic [31:0] head_addr;
  logic        head_elig;
  logic        act;
  logic        issue_en;
  logic        start;
  logic        pop_mem;
  logic        pop_exc;
  logic        pop;

  assign head_addr = vj_q[head_q] + imm_q[head_q];
  assign head_elig = busy_q[head_q] && !dj_q[head_q] && !dk_q[head_q] &&
                     (!typ_q[head_q][3] || cmt_q[head_q]);
  assign act       = rdy_in && !clear;
  assign issue_en  = act && dec_valid && !full_q;

`ifdef LSQ_MISALIGN_CHK_EN
  logic head_misal;
  assign head_misal = ((typ_q[head_q][1:0] == 2'b01) && head_addr[0]) ||
                      ((typ_q[head_q][1:0] == 2'b10) && (head_addr[1:0] != 2'b00));
  assign pop_exc    = act && (state_q == ST_IDLE) && head_elig && head_misal;
`else
  logic head_misal;
  assign head_misal = 1'b0;
  assign pop_exc    = 1'b0;
`endif

  assign start   = act && (state_q == ST_IDLE) && head_elig && !head_misal;
  assign pop_mem = act && (state_q == ST_WAIT) && mem_done;
  assign pop     = pop_mem || pop_exc;

  // Pointer, occupancy and full-flag next state
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (issue_en) tail_d = tail_q + PTR_ONE;
      if (pop)      head_d = head_q + PTR_ONE;
      count_d = count_q + CNT_W'(issue_en) - CNT_W'(pop);
    end
    full_d = (count_d == CNT_FULL);
  end

  // Memory FSM next state; a flush mid-access keeps the request alive in DRAIN
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_WAIT;
      ST_WAIT: begin
        if (clear)         state_d = mem_done ? ST_IDLE : ST_DRAIN;
        else if (mem_done) state_d = ST_IDLE;
      end
      ST_DRAIN: if (mem_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Entry array: issue write with bypass, wakeup, commit marking and pop
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        busy_q[i] <= 1'b0;
        typ_q[i]  <= '0;
        vj_q[i]   <= '0;
        vk_q[i]   <= '0;
        dj_q[i]   <= 1'b0;
        dk_q[i]   <= 1'b0;
        qj_q[i]   <= '0;
        qk_q[i]   <= '0;
        imm_q[i]  <= '0;
        rob_q[i]  <= '0;
        cmt_q[i]  <= 1'b0;
      end
    end else if (rdy_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (clear) begin
          busy_q[i] <= 1'b0;
          cmt_q[i]  <= 1'b0;
        end else if (issue_en && (tail_q == PTR_W'(i))) begin
          busy_q[i] <= 1'b1;
          typ_q[i]  <= dec_type;
          vj_q[i]   <= (dec_dj && ij[32]) ? ij[31:0] : dec_vj;
          vk_q[i]   <= (dec_dk && ik[32]) ? ik[31:0] : dec_vk;
          dj_q[i]   <= dec_dj && !ij[32];
          dk_q[i]   <= dec_dk && !ik[32];
          qj_q[i]   <= dec_qj;
          qk_q[i]   <= dec_qk;
          imm_q[i]  <= dec_imm;
          rob_q[i]  <= dec_rob_id;
          cmt_q[i]  <= 1'b0;
        end else if (busy_q[i]) begin
          if (pop && (head_q == PTR_W'(i))) busy_q[i] <= 1'b0;
          if (dj_q[i] && wj[i][32]) begin
            vj_q[i] <= wj[i][31:0];
            dj_q[i] <= 1'b0;
          end
          if (dk_q[i] && wk[i][32]) begin
            vk_q[i] <= wk[i][31:0];
            dk_q[i] <= 1'b0;
          end
          if (commit_valid && typ_q[i][3] && (rob_q[i] == commit_rob_id)) cmt_q[i] <= 1'b1;
        end
      end
    end
  end

  // Control registers: pointers, count, full flag and FSM state
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      state_q <= ST_IDLE;
    end else if (rdy_in) begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      full_q  <= full_d;
      state_q <= state_d;
    end
  end

  // Memory request registers: latched when the access starts, held until done
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_type_q  <= '0;
    end else if (rdy_in) begin
      mem_req_q <= (state_d != ST_IDLE);
      if (start) begin
        mem_addr_q  <= head_addr;
        mem_wdata_q <= vk_q[head_q];
        mem_type_q  <= typ_q[head_q];
      end
    end
  end

  // Result broadcast: one-cycle pulse per pop, stores report zero
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      out_valid_q  <= 1'b0;
      out_rob_id_q <= '0;
      out_value_q  <= '0;
    end else if (rdy_in) begin
      out_valid_q <= pop;
      if (pop) begin
        out_rob_id_q <= rob_q[head_q];
        out_value_q  <= (pop_mem && !mem_type_q[3]) ? load_ext(mem_type_q, mem_rdata) : 32'd0;
      end
    end
  end

`ifdef LSQ_MISALIGN_CHK_EN
  logic out_exc_q;
  // Exception flag accompanies the result pulse of a trapped misaligned op
  always_ff @(posedge clk_in) begin
    if (rst_in)      out_exc_q <= 1'b0;
    else if (rdy_in) out_exc_q <= pop_exc;
  end
  assign out_exc = out_exc_q;
`else
  assign out_exc = 1'b0;
`endif

  assign full       = full_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_type   = mem_type_q;
  assign out_valid  = out_valid_q;
  assign out_rob_id = out_rob_id_q;
  assign out_value  = out_value_q;

endmodule

// File: tb/tb_lsq_param.sv
// tb_lsq_param: directed bench for lsq_param (default build, 8 entries, 2 CDB channels).
module tb_lsq_param;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        clear = 1'b0;
  logic        full;
  logic        dec_valid = 1'b0;
  logic [3:0]  dec_type = '0;
  logic [31:0] dec_vj = '0, dec_vk = '0;
  logic        dec_dj = 1'b0, dec_dk = 1'b0;
  logic [3:0]  dec_qj = '0, dec_qk = '0;
  logic [31:0] dec_imm = '0;
  logic [3:0]  dec_rob_id = '0;
  logic [1:0]  cdb_valid = '0;
  logic [7:0]  cdb_rob_id = '0;
  logic [63:0] cdb_value = '0;
  logic        commit_valid = 1'b0;
  logic [3:0]  commit_rob_id = '0;
  logic        mem_req;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_type;
  logic        mem_done = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        out_valid;
  logic [3:0]  out_rob_id;
  logic [31:0] out_value;
  logic        out_exc;

  int checks = 0;
  int failures = 0;

  lsq_param #(.DEPTH(8), .ROB_W(4), .CDB_N(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear), .full(full),
    .dec_valid(dec_valid), .dec_type(dec_type), .dec_vj(dec_vj), .dec_vk(dec_vk),
    .dec_dj(dec_dj), .dec_dk(dec_dk), .dec_qj(dec_qj), .dec_qk(dec_qk),
    .dec_imm(dec_imm), .dec_rob_id(dec_rob_id),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value),
    .commit_valid(commit_valid), .commit_rob_id(commit_rob_id),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_type(mem_type),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_rob_id(out_rob_id), .out_value(out_value), .out_exc(out_exc)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge clk_in);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_dec(input logic [3:0] t, input logic [31:0] vj, input logic [31:0] vk,
                         input logic dj, input logic [3:0] qj, input logic [31:0] imm,
                         input logic [3:0] rob);
    dec_type = t; dec_vj = vj; dec_vk = vk; dec_dj = dj; dec_qj = qj;
    dec_dk = 1'b0; dec_qk = '0; dec_imm = imm; dec_rob_id = rob;
  endtask

  task automatic issue(input logic [3:0] t, input logic [31:0] vj, input logic [31:0] vk,
                       input logic dj, input logic [3:0] qj, input logic [31:0] imm,
                       input logic [3:0] rob);
    set_dec(t, vj, vk, dj, qj, imm, rob);
    dec_valid = 1'b1;
    tick();
    dec_valid = 1'b0;
    $display("issue type=%b rob=%0d vj=%h imm=%h dj=%0d", t, rob, vj, imm, dj);
  endtask

  task automatic wait_req(input string tag, input int budget);
    int n = 0;
    while (mem_req !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_req"}, {31'd0, mem_req}, 32'd1);
  endtask

  task automatic finish_access(input string tag, input logic [31:0] rdata,
                               input logic [3:0] rob, input logic [31:0] exp_val);
    mem_done = 1'b1;
    mem_rdata = rdata;
    tick();
    mem_done = 1'b0;
    chk({tag, "_ov"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_rob"}, {28'd0, out_rob_id}, {28'd0, rob});
    chk({tag, "_val"}, out_value, exp_val);
    chk({tag, "_exc"}, {31'd0, out_exc}, 32'd0);
    chk({tag, "_reqlow"}, {31'd0, mem_req}, 32'd0);
    $display("done %s rob=%0d rdata=%h value=%h", tag, out_rob_id, rdata, out_value);
    tick();
    chk({tag, "_pulse"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    logic [3:0] drain_list [8];
    drain_list = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd10, 4'd11};

    // Reset values
    tick(); tick(); tick();
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_type", {28'd0, mem_type}, 32'd0);
    chk("rst_ov", {31'd0, out_valid}, 32'd0);
    chk("rst_rob", {28'd0, out_rob_id}, 32'd0);
    chk("rst_val", out_value, 32'd0);
    chk("rst_exc", {31'd0, out_exc}, 32'd0);
    rst_in = 1'b0;
    tick();

    // LW 0x100+4: request exactly two cycles after issue
    issue(4'b0010, 32'h100, 32'h0, 1'b0, 4'd0, 32'd4, 4'd5);
    chk("lw_req_early", {31'd0, mem_req}, 32'd0);
    tick();
    chk("lw_req_n2", {31'd0, mem_req}, 32'd1);
    chk("lw_addr", mem_addr, 32'h104);
    chk("lw_type", {28'd0, mem_type}, 32'h2);
    finish_access("lw", 32'hDEADBEEF, 4'd5, 32'hDEADBEEF);

    // Load extension, with junk above the accessed bytes
    issue(4'b0000, 32'h200, 32'h0, 1'b0, 4'd0, 32'd1, 4'd1);
    wait_req("lb", 4);
    finish_access("lb", 32'hAABBCC80, 4'd1, 32'hFFFFFF80);
    issue(4'b0100, 32'h200, 32'h0, 1'b0, 4'd0, 32'd1, 4'd2);
    wait_req("lbu", 4);
    finish_access("lbu", 32'hAABBCC80, 4'd2, 32'h00000080);
    issue(4'b0001, 32'h200, 32'h0, 1'b0, 4'd0, 32'd2, 4'd3);
    wait_req("lh", 4);
    finish_access("lh", 32'h00008001, 4'd3, 32'hFFFF8001);
    issue(4'b0101, 32'h200, 32'h0, 1'b0, 4'd0, 32'd2, 4'd4);
    wait_req("lhu", 4);
    finish_access("lhu", 32'hFFFF8001, 4'd4, 32'h00008001);

    // Issue-time bypass: both channels match, channel 0 wins
    cdb_valid = 2'b11; cdb_rob_id = {4'd2, 4'd2}; cdb_value = {32'h400, 32'h300};
    issue(4'b0010, 32'hFFFF0000, 32'h0, 1'b1, 4'd2, 32'h10, 4'd6);
    cdb_valid = 2'b00;
    wait_req("byp", 4);
    chk("byp_addr", mem_addr, 32'h310);
    finish_access("byp", 32'h12345678, 4'd6, 32'h12345678);

    // SW waiting on tag 3 (woken by channel 1) and on commit
    issue(4'b1010, 32'hFFFF0000, 32'h55, 1'b1, 4'd3, 32'd8, 4'd7);
    cdb_valid = 2'b11; cdb_rob_id = {4'd3, 4'd9}; cdb_value = {32'h2000, 32'h0BAD};
    tick();
    cdb_valid = 2'b00;
    tick(); tick(); tick(); tick();
    chk("sw_nocommit", {31'd0, mem_req}, 32'd0);
    commit_valid = 1'b1; commit_rob_id = 4'd7;
    tick();
    commit_valid = 1'b0;
    wait_req("sw", 5);
    chk("sw_addr", mem_addr, 32'h2008);
    chk("sw_wdata", mem_wdata, 32'h55);
    chk("sw_type", {28'd0, mem_type}, 32'hA);
    finish_access("sw", 32'hFFFFFFFF, 4'd7, 32'd0);

    // Fill all 8 entries (pending on tag 14); tail wraps through 0
    for (int i = 0; i < 8; i++) begin
      if (i == 7) chk("full_at7", {31'd0, full}, 32'd0);
      set_dec(4'b0010, 32'hFFFF0000, 32'h0, 1'b1, 4'd14, 32'(i * 4), 4'(i));
      dec_valid = 1'b1;
      tick();
    end
    dec_valid = 1'b0;
    chk("full_at8", {31'd0, full}, 32'd1);
    issue(4'b0010, 32'h9000, 32'h0, 1'b0, 4'd0, 32'd0, 4'd8);
    chk("full_drop", {31'd0, full}, 32'd1);
    chk("full_noreq", {31'd0, mem_req}, 32'd0);
    cdb_valid = 2'b01; cdb_rob_id = {4'd0, 4'd14}; cdb_value = {32'h0, 32'h1000};
    tick();
    cdb_valid = 2'b00;

    // Pop while full with a concurrent issue: issue is dropped
    wait_req("f0", 5);
    chk("f0_addr", mem_addr, 32'h1000);
    set_dec(4'b0010, 32'h9000, 32'h0, 1'b0, 4'd0, 32'd0, 4'd9);
    dec_valid = 1'b1; mem_done = 1'b1; mem_rdata = 32'hC0DE0000;
    tick();
    dec_valid = 1'b0; mem_done = 1'b0;
    chk("f0_ov", {31'd0, out_valid}, 32'd1);
    chk("f0_rob", {28'd0, out_rob_id}, 32'd0);
    chk("f0_full", {31'd0, full}, 32'd0);
    $display("done f0 rob=%0d value=%h", out_rob_id, out_value);

    // Pop and issue together at DEPTH-1: count stays, then one more fills
    wait_req("f1", 4);
    chk("f1_addr", mem_addr, 32'h1004);
    set_dec(4'b0010, 32'h1000, 32'h0, 1'b0, 4'd0, 32'h28, 4'd10);
    dec_valid = 1'b1; mem_done = 1'b1; mem_rdata = 32'hC0DE0001;
    tick();
    dec_valid = 1'b0; mem_done = 1'b0;
    chk("f1_rob", {28'd0, out_rob_id}, 32'd1);
    chk("f1_full", {31'd0, full}, 32'd0);
    $display("done f1 rob=%0d value=%h", out_rob_id, out_value);
    issue(4'b0010, 32'h1000, 32'h0, 1'b0, 4'd0, 32'h2C, 4'd11);
    chk("f11_full", {31'd0, full}, 32'd1);

    // Drain in order; consecutive accesses have one idle cycle
    for (int k = 0; k < 8; k++) begin
      if (k > 0) chk("b2b_req", {31'd0, mem_req}, 32'd1);
      wait_req("drn", 4);
      chk("drn_addr", mem_addr, 32'h1000 + 32'(drain_list[k]) * 32'd4);
      finish_access("drn", 32'hC0DE0000 | 32'(drain_list[k]), drain_list[k],
                    32'hC0DE0000 | 32'(drain_list[k]));
    end
    tick(); tick();
    chk("drn_empty", {31'd0, mem_req}, 32'd0);

    // Flush while a committed store is in flight
    issue(4'b1010, 32'h3000, 32'h77, 1'b0, 4'd0, 32'd0, 4'd12);
    commit_valid = 1'b1; commit_rob_id = 4'd12;
    tick();
    commit_valid = 1'b0;
    wait_req("clr", 5);
    chk("clr_wdata", mem_wdata, 32'h77);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_hold1", {31'd0, mem_req}, 32'd1);
    tick(); tick();
    chk("clr_hold2", {31'd0, mem_req}, 32'd1);
    chk("clr_addr", mem_addr, 32'h3000);
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    chk("clr_noov", {31'd0, out_valid}, 32'd0);
    chk("clr_reqlow", {31'd0, mem_req}, 32'd0);
    tick(); tick(); tick(); tick();
    chk("clr_empty", {31'd0, mem_req}, 32'd0);
    chk("clr_noov2", {31'd0, out_valid}, 32'd0);
    chk("clr_full", {31'd0, full}, 32'd0);
    $display("clear drained store rob=12");
    issue(4'b0010, 32'h40, 32'h0, 1'b0, 4'd0, 32'd4, 4'd13);
    wait_req("post", 4);
    chk("post_addr", mem_addr, 32'h44);
    finish_access("post", 32'h11223344, 4'd13, 32'h11223344);

    // Misaligned word goes to memory in this build; stall freezes completion
    issue(4'b0010, 32'h100, 32'h0, 1'b0, 4'd0, 32'd2, 4'd14);
    wait_req("mis", 4);
    chk("mis_addr", mem_addr, 32'h102);
    rdy_in = 1'b0; mem_done = 1'b1; mem_rdata = 32'h0;
    tick();
    mem_done = 1'b0;
    chk("stall_noov", {31'd0, out_valid}, 32'd0);
    chk("stall_req", {31'd0, mem_req}, 32'd1);
    rdy_in = 1'b1;
    finish_access("mis", 32'hCAFEF00D, 4'd14, 32'hCAFEF00D);

    // Reset in the middle of an access abandons it
    issue(4'b0010, 32'h0, 32'h0, 1'b0, 4'd0, 32'd8, 4'd15);
    wait_req("rw", 4);
    rst_in = 1'b1;
    tick();
    chk("rw_req", {31'd0, mem_req}, 32'd0);
    chk("rw_addr", mem_addr, 32'd0);
    rst_in = 1'b0;
    tick(); tick(); tick();
    chk("rw_empty", {31'd0, mem_req}, 32'd0);
    chk("rw_ov", {31'd0, out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
